// File: rtl/cpu_stack_wb.sv
// cpu_stack_wb: stage-4 stack writeback; applies pop/push ops to a two-register
// top-of-stack backed by a single-port synchronous spill RAM, and stalls upstream
// while the top registers are refilled from RAM.
//
// Ports:
//   clk, rst_b        clock, asynchronous active-low reset
//   st__valid_4a      stack op present this cycle
//   st__push_4a       op pushes st__to_push_4a (applied after the pops)
//   st__to_push_4a    tagged word to push
//   st__to_pop_4a     number of entries to pop
//   st__stall         refill in progress; upstream holds its op
//   st__top0/top1     top and second entries (0 when absent)
//   st__depth         current entry count
//   st__overflow      sticky: push attempted at capacity
//   st__underflow     sticky: pop count exceeded depth
//   st__hwm           high-water mark of depth (only with STACK_HWM_EN defined)
//
// Optional feature macro: STACK_HWM_EN
module cpu_stack_wb #(
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 35
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              st__valid_4a,
    input  logic              st__push_4a,
    input  logic [WIDTH-1:0]  st__to_push_4a,
    input  logic [10:0]       st__to_pop_4a,
    output logic              st__stall,
    output logic [WIDTH-1:0]  st__top0,
    output logic [WIDTH-1:0]  st__top1,
    output logic [ADDR_W:0]   st__depth,
`ifdef STACK_HWM_EN
    output logic [ADDR_W:0]   st__hwm,
`endif
    output logic              st__overflow,
    output logic              st__underflow
);
    localparam int DW  = ADDR_W + 1;
    localparam int CW  = (DW > 11) ? DW + 1 : 12;
    localparam int CAP = (1 << ADDR_W) + 2;

    typedef enum logic [2:0] {IDLE, FILL_T1, FILL_BOTH, FILL_LAST, FILL_T0} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  top0_q, top1_q;
    logic [DW-1:0]     depth_q, depth_d;
    logic              ovf_q, unf_q;
    logic [ADDR_W-1:0] fill_addr_q;
`ifdef STACK_HWM_EN
    logic [DW-1:0]     hwm_q;
`endif

    logic [WIDTH-1:0]  mem_q [2**ADDR_W];
    logic [WIDTH-1:0]  rdata_q;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;

    logic              acc, unf, ovf, p;
    logic [DW-1:0]     n, e;

    always_comb begin
        acc     = st__valid_4a && (state_q == IDLE);
        unf     = CW'(st__to_pop_4a) > CW'(depth_q);
        n       = unf ? depth_q : DW'(st__to_pop_4a);
        e       = depth_q - n;
        ovf     = st__push_4a && (e == DW'(CAP));
        p       = st__push_4a && !ovf;
        depth_d = e + DW'(p);
    end

    // Single RAM port: the second FILL_BOTH read owns it, otherwise the accepted
    // op decides between a spill write and a refill read.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        if (state_q == FILL_BOTH) begin
            ram_addr = fill_addr_q;
        end else if (acc) begin
            if (n == '0) begin
                ram_we   = p && (depth_q >= DW'(2));
                ram_addr = ADDR_W'(depth_q - DW'(2));
            end else if (n == DW'(1)) begin
                ram_addr = ADDR_W'(depth_q - DW'(3));
            end else begin
                ram_addr = ADDR_W'(e - DW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            mem_q[ram_addr] <= top1_q;
        rdata_q <= mem_q[ram_addr];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            top0_q      <= '0;
            top1_q      <= '0;
            depth_q     <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            fill_addr_q <= '0;
`ifdef STACK_HWM_EN
            hwm_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc) begin
                        depth_q <= depth_d;
                        if (unf) unf_q <= 1'b1;
                        if (ovf) ovf_q <= 1'b1;
`ifdef STACK_HWM_EN
                        if (depth_d > hwm_q) hwm_q <= depth_d;
`endif
                        if (n == '0) begin
                            if (p) begin
                                top0_q <= st__to_push_4a;
                                top1_q <= top0_q;
                            end
                        end else if (n == DW'(1)) begin
                            if (p) begin
                                top0_q <= st__to_push_4a;
                            end else begin
                                top0_q <= top1_q;
                                if (depth_d >= DW'(2)) state_q <= FILL_T1;
                                else top1_q <= '0;
                            end
                        end else if (p) begin
                            top0_q <= st__to_push_4a;
                            if (depth_d >= DW'(2)) state_q <= FILL_T1;
                            else top1_q <= '0;
                        end else begin
                            // Both tops are refilled; clear them so empty slots read 0.
                            top0_q      <= '0;
                            top1_q      <= '0;
                            fill_addr_q <= ADDR_W'(e - DW'(2));
                            if (e >= DW'(2)) state_q <= FILL_BOTH;
                            else if (e == DW'(1)) state_q <= FILL_T0;
                        end
                    end
                end
                FILL_T1: begin
                    top1_q  <= rdata_q;
                    state_q <= IDLE;
                end
                FILL_T0: begin
                    top0_q  <= rdata_q;
                    state_q <= IDLE;
                end
                FILL_BOTH: begin
                    top0_q  <= rdata_q;
                    state_q <= FILL_LAST;
                end
                FILL_LAST: begin
                    top1_q  <= rdata_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign st__stall     = (state_q != IDLE);
    assign st__top0      = top0_q;
    assign st__top1      = top1_q;
    assign st__depth     = depth_q;
    assign st__overflow  = ovf_q;
    assign st__underflow = unf_q;
`ifdef STACK_HWM_EN
    assign st__hwm       = hwm_q;
`endif

endmodule

// File: tb/tb_cpu_stack_wb.sv
// tb_cpu_stack_wb: directed self-checking bench for cpu_stack_wb (ADDR_W=2, CAP=6).
module tb_cpu_stack_wb;
    localparam int AW = 2;
    localparam int W  = 35;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          valid = 1'b0;
    logic          push = 1'b0;
    logic [W-1:0]  word = '0;
    logic [10:0]   pop = '0;
    logic          stall;
    logic [W-1:0]  top0, top1;
    logic [AW:0]   depth;
    logic          ovf, unf;
`ifdef STACK_HWM_EN
    logic [AW:0]   hwm;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_stack_wb #(.ADDR_W(AW), .WIDTH(W)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .st__valid_4a   (valid),
        .st__push_4a    (push),
        .st__to_push_4a (word),
        .st__to_pop_4a  (pop),
        .st__stall      (stall),
        .st__top0       (top0),
        .st__top1       (top1),
        .st__depth      (depth),
`ifdef STACK_HWM_EN
        .st__hwm        (hwm),
`endif
        .st__overflow   (ovf),
        .st__underflow  (unf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One op presented for one edge; outputs sampled 1ns after that edge.
    task automatic op(input logic ps, input logic [W-1:0] w, input int n);
        valid = 1'b1;
        push  = ps;
        word  = w;
        pop   = 11'(n);
        @(posedge clk);
        #1;
        valid = 1'b0;
        push  = 1'b0;
        pop   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (stall && k < 10) begin
            tick();
            k++;
        end
        chk(tag, {63'd0, stall}, 64'd0);
    endtask

    initial begin
        #1;
        chk("rst_stall", {63'd0, stall}, 0);
        chk("rst_depth", 64'(depth), 0);
        chk("rst_top0", 64'(top0), 0);
        chk("rst_top1", 64'(top1), 0);
        chk("rst_flags", {62'd0, ovf, unf}, 0);
        repeat (2) @(posedge clk);
        #3 rst_b = 1'b1;
        tick();

        op(1, 35'h11, 0); chk("p1_stall", {63'd0, stall}, 0);
        op(1, 35'h22, 0); chk("p2_stall", {63'd0, stall}, 0);
        op(1, 35'h33, 0); chk("p3_stall", {63'd0, stall}, 0);
        chk("p3_top0", 64'(top0), 64'h33);
        chk("p3_top1", 64'(top1), 64'h22);
        chk("p3_depth", 64'(depth), 3);

        op(1, 35'h55, 2);
        chk("n2p1_top0", 64'(top0), 64'h55);
        chk("n2p1_stall", {63'd0, stall}, 1);
        chk("n2p1_depth", 64'(depth), 2);
        tick();
        chk("n2p1_stall_end", {63'd0, stall}, 0);
        chk("n2p1_top1", 64'(top1), 64'h11);

        op(0, '0, 2);
        chk("clr_depth", 64'(depth), 0);
        chk("clr_tops", {top0, top1} == '0 ? 64'd0 : 64'd1, 0);
        chk("clr_stall", {63'd0, stall}, 0);

        for (int i = 1; i <= 5; i++) op(1, 35'(i), 0);
        chk("p5_depth", 64'(depth), 5);
        op(0, '0, 3);
        chk("fb_stall1", {63'd0, stall}, 1);
        chk("fb_depth", 64'(depth), 2);
        valid = 1'b1; push = 1'b1; word = 35'h99;
        tick();
        chk("fb_stall2", {63'd0, stall}, 1);
        tick();
        valid = 1'b0; push = 1'b0;
        chk("fb_stall3", {63'd0, stall}, 0);
        chk("fb_top0", 64'(top0), 2);
        chk("fb_top1", 64'(top1), 1);
        chk("fb_ignored", 64'(depth), 2);

        op(1, 35'h3, 0);
        op(1, 35'h4, 0);
        op(0, '0, 1);
        chk("n1_top0", 64'(top0), 3);
        chk("n1_stall", {63'd0, stall}, 1);
        tick();
        chk("n1_top1", 64'(top1), 2);
        chk("n1_depth", 64'(depth), 3);
        op(1, 35'h77, 1);
        chk("rep_top0", 64'(top0), 64'h77);
        chk("rep_top1", 64'(top1), 2);
        chk("rep_depth", 64'(depth), 3);

        op(0, '0, 2);
        wait_idle("t0_idle");
        chk("t0_top0", 64'(top0), 1);
        chk("t0_top1", 64'(top1), 0);
        chk("t0_depth", 64'(depth), 1);
        op(0, '0, 3);
        chk("unf_flag", {63'd0, unf}, 1);
        chk("unf_depth", 64'(depth), 0);
        chk("unf_tops", {top0, top1} == '0 ? 64'd0 : 64'd1, 0);
        op(1, 35'h7_000000AA, 0);
        chk("unf_sticky", {63'd0, unf}, 1);
        chk("unf_push_top0", 64'(top0), 64'h7_000000AA);
        op(0, '0, 1);
        chk("pop_empty_depth", 64'(depth), 0);
        chk("pop_empty_top0", 64'(top0), 0);

        for (int i = 1; i <= 6; i++) op(1, 35'(i), 0);
        chk("cap_depth", 64'(depth), 6);
        chk("cap_ovf0", {63'd0, ovf}, 0);
        op(1, 35'h7, 0);
        chk("ovf_flag", {63'd0, ovf}, 1);
        chk("ovf_depth", 64'(depth), 6);
        chk("ovf_top0", 64'(top0), 6);
        chk("ovf_top1", 64'(top1), 5);
`ifdef STACK_HWM_EN
        chk("hwm_cap", 64'(hwm), 6);
`endif

        op(0, '0, 2);
        chk("rfb_stall", {63'd0, stall}, 1);
        #2 rst_b = 1'b0;
        #1;
        chk("rfb_stall0", {63'd0, stall}, 0);
        chk("rfb_depth", 64'(depth), 0);
        chk("rfb_flags", {62'd0, ovf, unf}, 0);
        chk("rfb_top0", 64'(top0), 0);
        #2 rst_b = 1'b1;
        op(1, 35'h5A, 0);
        chk("post_rst_depth", 64'(depth), 1);
        chk("post_rst_top0", 64'(top0), 64'h5A);
        chk("post_rst_top1", 64'(top1), 0);
`ifdef STACK_HWM_EN
        chk("hwm_post_rst", 64'(hwm), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
